// File: rtl/conv_psum_collector.sv
// Serially reduces the packed lane sums of one adder-array word into a scalar,
// accumulates num_channels words, and hands the saturated result downstream.
module conv_psum_collector #(
    parameter int lane_width   = 19,
    parameter int array_size   = 2,
    parameter int num_channels = 3,
    parameter int acc_width    = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [lane_width*array_size-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [acc_width-1:0]             out_data,
    output logic                             out_sat
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    localparam int LIW = (array_size > 1) ? $clog2(array_size) : 1;
    localparam int CW  = (num_channels > 1) ? $clog2(num_channels) : 1;

    localparam logic [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

    logic [1:0]                        state;
    logic [lane_width*array_size-1:0]  word;
    logic [LIW-1:0]                    lane_idx;
    logic [CW-1:0]                     chan_cnt;
    logic [acc_width-1:0]              acc;

    logic [lane_width-1:0] lanes [array_size];
    logic [lane_width-1:0] cur_lane;
    logic [acc_width:0]    sum;
    logic [acc_width-1:0]  sum_sat;
    logic                  ovf;
    logic                  last_lane;
    logic                  last_chan;

    genvar g;
    generate
        for (g = 0; g < array_size; g++) begin : g_lane
            assign lanes[g] = word[g*lane_width +: lane_width];
        end
    endgenerate

    assign cur_lane = lanes[lane_idx];

    // One extra bit of headroom: the sign of the widened sum picks the clamp rail.
    assign sum = {acc[acc_width-1], acc}
               + {{(acc_width+1-lane_width){cur_lane[lane_width-1]}}, cur_lane};
    assign ovf     = sum[acc_width] != sum[acc_width-1];
    assign sum_sat = !ovf ? sum[acc_width-1:0] : (sum[acc_width] ? ACC_MIN : ACC_MAX);

    assign last_lane = lane_idx == LIW'(array_size - 1);
    assign last_chan = chan_cnt == CW'(num_channels - 1);

    assign in_ready = reset && enable && (state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            word      <= '0;
            lane_idx  <= '0;
            chan_cnt  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        word     <= in_data;
                        lane_idx <= '0;
                        state    <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    acc      <= sum_sat;
                    lane_idx <= lane_idx + 1'b1;
                    if (ovf)
                        out_sat <= 1'b1;
                    if (last_lane) begin
                        lane_idx <= '0;
                        if (last_chan) begin
                            chan_cnt  <= '0;
                            out_valid <= 1'b1;
                            out_data  <= sum_sat;
                            state     <= S_OUT;
                        end else begin
                            chan_cnt <= chan_cnt + 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_OUT: begin
                    // The consume edge only returns to idle; the next accept is a cycle later.
                    if (out_ready) begin
                        acc       <= '0;
                        out_sat   <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_psum_collector.sv
// Bench for conv_psum_collector: three instances (defaults, acc_width=20,
// num_channels=1) share one stimulus set; each scenario checks one of them.
module tb_conv_psum_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [37:0] in_data;
    logic        out_ready;

    logic               rdy0, rdy1, rdy2;
    logic               ov0, ov1, ov2;
    logic               os0, os1, os2;
    logic signed [23:0] od0, od2;
    logic signed [19:0] od1;
    logic [2:0]         rdy_v, ov_v;

    int n_chk  = 0;
    int n_pass = 0;

    assign rdy_v = {rdy2, rdy1, rdy0};
    assign ov_v  = {ov2, ov1, ov0};

    always #5 clk = ~clk;

    conv_psum_collector u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0));

    conv_psum_collector #(.acc_width(20)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1));

    conv_psum_collector #(.num_channels(1)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    // Present a word and hold it until instance sel takes it on an edge.
    task automatic send(input int sel, input int l1, input int l0);
        int t;
        t = 0;
        in_data  = {19'(l1), 19'(l0)};
        in_valid = 1'b1;
        #1;
        while (!rdy_v[sel] && t < 50) begin tick(); t++; end
        if (t >= 50) begin
            n_chk++;
            $display("FAIL send_timeout dut%0d waited %0d cycles for in_ready", sel, t);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (!ov_v[sel] && n < 100) begin tick(); n++; end
    endtask

    // Reference: one saturating add in plain integer arithmetic.
    function automatic longint sat_add(input longint a, input longint b, input int aw,
                                       output bit clamped);
        longint hi, lo, v;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        v = a + b;
        clamped = 1'b0;
        if (v > hi) begin v = hi; clamped = 1'b1; end
        else if (v < lo) begin v = lo; clamped = 1'b1; end
        return v;
    endfunction

    function automatic logic [18:0] rlane();
        case ($urandom_range(0, 3))
            0: return 19'h3FFFF;
            1: return 19'h40000;
            default: return 19'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
        tick(); tick();
        n_chk++; if (rdy_v !== 3'b000) $display("FAIL reset_in_ready got %b exp 000", rdy_v); else n_pass++;
        n_chk++; if (ov_v !== 3'b000) $display("FAIL reset_out_valid got %b exp 000", ov_v); else n_pass++;
        n_chk++; if (od0 !== 24'sd0 || od1 !== 20'sd0) $display("FAIL reset_out_data got %0d/%0d exp 0", od0, od1); else n_pass++;
        n_chk++; if ({os2, os1, os0} !== 3'b000) $display("FAIL reset_out_sat got %b exp 000", {os2, os1, os0}); else n_pass++;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_chk++; if (rdy_v !== 3'b111) $display("FAIL reset_release_ready got %b exp 111", rdy_v); else n_pass++;
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        send(0, 5, 3); send(0, 10, 20); send(0, -4, 1);
        wait_valid(0, n);
        n_chk++; if (n != 2) $display("FAIL basic_latency got %0d exp 2", n); else n_pass++;
        n_chk++; if (od0 !== 24'sd35) $display("FAIL basic_data got %0d exp 35", od0); else n_pass++;
        n_chk++; if (os0 !== 1'b0) $display("FAIL basic_sat got %b exp 0", os0); else n_pass++;
        tick();
        n_chk++; if (ov0 !== 1'b0) $display("FAIL basic_one_cycle got %b exp 0", ov0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        out_ready = 1'b0;
        send(0, 5, 3); send(0, 10, 20); send(0, -4, 1);
        wait_valid(0, n);
        n_chk++; if (n != 2) $display("FAIL bp_latency got %0d exp 2", n); else n_pass++;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if (ov0 !== 1'b1 || od0 !== 24'sd35 || rdy0 !== 1'b0 || os0 !== 1'b0)
                $display("FAIL bp_hold cyc%0d got v=%b d=%0d r=%b s=%b exp v=1 d=35 r=0 s=0", i, ov0, od0, rdy0, os0);
            else n_pass++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (ov0 !== 1'b0 || rdy0 !== 1'b1) $display("FAIL bp_consume got v=%b r=%b exp v=0 r=1", ov0, rdy0); else n_pass++;
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) send(1, 262143, 262143);
        wait_valid(1, n);
        n_chk++; if (od1 !== 20'sh7FFFF || os1 !== 1'b1) $display("FAIL sat_pos got %0d/%b exp 524287/1", od1, os1); else n_pass++;
        tick();
        n_chk++; if (os1 !== 1'b0) $display("FAIL sat_clear got %b exp 0", os1); else n_pass++;
        for (int i = 0; i < 3; i++) send(1, -262144, -262144);
        wait_valid(1, n);
        n_chk++; if (od1 !== 20'sh80000 || os1 !== 1'b1) $display("FAIL sat_neg got %0d/%b exp -524288/1", od1, os1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        send(0, 5, 3); send(0, 10, 20); send(0, -4, 1);
        wait_valid(0, n);
        tick();
        send(0, 5, 3); send(0, 10, 20);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (ov0 !== 1'b0 || od0 !== 24'sd0 || os0 !== 1'b0 || rdy0 !== 1'b0)
            $display("FAIL rstmid_outputs got v=%b d=%0d s=%b r=%b exp all 0", ov0, od0, os0, rdy0);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        send(0, 1, 1); send(0, 1, 1); send(0, 1, 1);
        wait_valid(0, n);
        n_chk++; if (n != 2 || od0 !== 24'sd6 || os0 !== 1'b0) $display("FAIL rstmid_result got n=%0d d=%0d s=%b exp n=2 d=6 s=0", n, od0, os0); else n_pass++;
    endtask

    task automatic test_enable_stall();
        int n;
        do_reset();
        out_ready = 1'b0;
        send(0, 5, 3); send(0, 10, 20); send(0, -4, 1);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (ov0 !== 1'b0 || rdy0 !== 1'b0) $display("FAIL stall_frozen cyc%0d got v=%b r=%b exp 0/0", i, ov0, rdy0); else n_pass++;
            tick();
        end
        enable = 1'b1;
        wait_valid(0, n);
        n_chk++; if (n != 1) $display("FAIL stall_latency got %0d exp 1 (5 after accept)", n); else n_pass++;
        n_chk++; if (od0 !== 24'sd35) $display("FAIL stall_data got %0d exp 35", od0); else n_pass++;
        in_valid = 1'b1; in_data = {19'd1, 19'd1};
        tick(); tick();
        n_chk++; if (ov0 !== 1'b1 || rdy0 !== 1'b0 || od0 !== 24'sd35) $display("FAIL out_no_accept got v=%b r=%b d=%0d exp 1/0/35", ov0, rdy0, od0); else n_pass++;
        in_valid = 1'b0; enable = 1'b0; out_ready = 1'b1;
        tick();
        n_chk++; if (ov0 !== 1'b1) $display("FAIL disabled_consume got v=%b exp 1", ov0); else n_pass++;
        enable = 1'b1;
        tick();
        n_chk++; if (ov0 !== 1'b0) $display("FAIL enabled_consume got v=%b exp 0", ov0); else n_pass++;
        send(0, 1, 1); send(0, 1, 1); send(0, 1, 1);
        wait_valid(0, n);
        n_chk++; if (od0 !== 24'sd6) $display("FAIL after_out_data got %0d exp 6", od0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int last, nacc;
        do_reset();
        last = -1; nacc = 0;
        in_data = {19'd7, 19'h7FFFE};
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (rdy2) begin
                if (last >= 0) begin
                    n_chk++; if (cyc - last != 4) $display("FAIL b2b_spacing got %0d exp 4", cyc - last); else n_pass++;
                end
                last = cyc; nacc++;
            end
            if (ov2) begin
                n_chk++; if (od2 !== 24'sd5 || os2 !== 1'b0) $display("FAIL b2b_data got %0d/%b exp 5/0", od2, os2); else n_pass++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (nacc < 9) $display("FAIL b2b_count got %0d exp >=9", nacc); else n_pass++;
    endtask

    // Random traffic on the two 3-channel instances against a word-level model.
    task automatic test_random();
        longint exp_d [2][$];
        bit     exp_s [2][$];
        longint acc_m [2];
        bit     sat_m [2];
        int     cnt_m [2];
        int     aw    [2];
        bit     prev_hold [2];
        longint prev_d [2];
        longint cur_d, ed, l;
        bit     cur_v, cur_r, cur_s, es, c;
        aw[0] = 24; aw[1] = 20;
        for (int d = 0; d < 2; d++) begin acc_m[d] = 0; sat_m[d] = 0; cnt_m[d] = 0; prev_hold[d] = 0; prev_d[d] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc < 800) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = {rlane(), rlane()};
                enable    = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                cur_v = ov_v[d]; cur_r = rdy_v[d];
                cur_d = (d == 0) ? longint'(od0) : longint'(od1);
                cur_s = (d == 0) ? os0 : os1;
                if (prev_hold[d] && cur_v) begin
                    n_chk++; if (cur_d != prev_d[d]) $display("FAIL rnd_stable dut%0d got %0d exp %0d", d, cur_d, prev_d[d]); else n_pass++;
                end
                if (cur_r && in_valid) begin
                    for (int k = 0; k < 2; k++) begin
                        l = longint'($signed(in_data[k*19 +: 19]));
                        acc_m[d] = sat_add(acc_m[d], l, aw[d], c);
                        sat_m[d] |= c;
                    end
                    cnt_m[d]++;
                    if (cnt_m[d] == 3) begin
                        exp_d[d].push_back(acc_m[d]); exp_s[d].push_back(sat_m[d]);
                        acc_m[d] = 0; sat_m[d] = 0; cnt_m[d] = 0;
                    end
                end
                if (cur_v && out_ready && enable) begin
                    n_chk++;
                    if (exp_d[d].size() == 0) $display("FAIL rnd_unexpected dut%0d got %0d", d, cur_d);
                    else begin
                        ed = exp_d[d].pop_front(); es = exp_s[d].pop_front();
                        if (cur_d != ed || cur_s != es) $display("FAIL rnd_result dut%0d got %0d/%b exp %0d/%b", d, cur_d, cur_s, ed, es);
                        else n_pass++;
                    end
                end
                prev_hold[d] = cur_v && !(out_ready && enable);
                prev_d[d] = cur_d;
            end
            tick();
        end
        n_chk++; if (exp_d[0].size() != 0 || exp_d[1].size() != 0) $display("FAIL rnd_drain left %0d/%0d results", exp_d[0].size(), exp_d[1].size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_enable_stall();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_psum_collector.md
Name: conv_psum_collector

Overview:
- Consumer-side counterpart of the convolution adder-tree array stages: reads the packed per-lane sums that an adder array stage emits and reduces them serially, one lane per cycle, into a single scalar.
- Accumulates that scalar over num_channels consecutive input words (the input channels of one output pixel).
- Presents the result downstream with a valid/ready handshake and a saturation flag.
- Sits between the last adder array stage and the activation/output buffer.

Parameters:
lane_width, 19, width of one packed lane (two's complement)
array_size, 2, number of lanes packed in in_data
num_channels, 3, input words accumulated per result (>=1)
acc_width, 24, accumulator/result width (>= lane_width+1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  global advance enable; low freezes the FSM and all registers
in_valid  input  1  in_data valid
in_ready  output  1  collector can accept in_data
in_data  input  lane_width*array_size  packed lane sums, lane i at bits [(i+1)*lane_width-1 : i*lane_width]
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  acc_width  accumulated signed result
out_sat  output  1  result saturated at least once during this accumulation

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE; acc, lane_idx, chan_cnt, captured word all 0; out_valid=0, out_data=0, out_sat=0; in_ready=0 while reset is asserted.
- enable=0:
  - No register or state changes.
  - in_ready forced 0.
  - out_valid and out_data hold their values.
  - A handshake never completes while enable=0.
- Handshake rules:
  - Input accepted on a rising edge with in_valid & in_ready & enable.
  - Output consumed on a rising edge with out_valid & out_ready & enable.
  - out_data and out_sat stay stable while out_valid=1 and out_ready=0.
- S_IDLE:
  - in_ready=1 when enable=1.
  - On accept: latch in_data, lane_idx=0, go to S_REDUCE.
- S_REDUCE:
  - in_ready=0.
  - Each enabled edge: acc <= sat(acc + sext(lane[lane_idx])); lane_idx++.
  - On the edge that adds lane array_size-1:
    - If chan_cnt==num_channels-1: chan_cnt=0, go to S_OUT, out_valid=1, out_data=the saturated sum.
    - Otherwise: chan_cnt++, return to S_IDLE.
- S_OUT:
  - in_ready=0, out_valid=1.
  - On consume: acc=0, out_sat=0, out_valid=0, go to S_IDLE.
  - No new input is accepted on the consume edge; the earliest next accept is one cycle later.
- Arithmetic:
  - Lanes are sign-extended to acc_width+1 before the add.
  - Result is clamped to [-2^(acc_width-1), 2^(acc_width-1)-1]; any clamp sets out_sat (sticky until consume).
  - Saturation is applied per add, never wrapped.
- Latency:
  - With enable held high, out_valid rises exactly array_size edges after the accept edge of the last channel word.
  - Minimum input spacing is array_size+1 cycles.
- num_channels=1: every input word produces one result.
- Reset mid-operation (any state): partial accumulation is discarded; the first word accepted after reset starts a new channel count at 0.

Test Plan:
- Defaults; inputs {lane1,lane0} = {5,3}, {10,20}, {-4,1}, enable=1, out_ready=1 -> one result out_data=35, out_sat=0; out_valid high 2 cycles after the third accept, for exactly 1 cycle.
- Same stimulus, out_ready=0 for 5 cycles after out_valid rises -> out_valid=1, out_data=35, in_ready=0 held for all 5 cycles; consume on out_ready=1; in_ready=1 one cycle later.
- acc_width=20; three words, all lanes 262143 -> out_data=524287, out_sat=1. Three words, all lanes -262144 -> out_data=-524288 (0x80000), out_sat=1.
- Pull reset low for 1 cycle during S_REDUCE of the second word -> outputs 0 immediately. Then feed {1,1} three times -> out_data=6, out_sat=0.
- enable=0 for 3 cycles in S_REDUCE of the last word -> out_valid is delayed by exactly 3 cycles, out_data unchanged (35 with the first scenario's stimulus). Assert in_valid during S_OUT -> no accept.
- num_channels=1, back-to-back in_valid with {7,-2} -> out_data=5 per word; accepts spaced 4 cycles apart with out_ready tied high.
